// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store.
// Define MEMARB_ROUNDROBIN_EN for round-robin arbitration; the default is fixed data-over-fetch priority.
module mem_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int INSTSIZE = 32,
  parameter int TIMEOUT  = 15,
  parameter int TOSIZE   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [WORDSIZE-1:0] if_addr,
  output logic                if_ready,
  output logic [INSTSIZE-1:0] if_data,
  output logic                if_stall,
  input  logic                dm_read,
  input  logic                dm_write,
  input  logic [WORDSIZE-1:0] dm_addr,
  input  logic [WORDSIZE-1:0] dm_wdata,
  output logic                dm_ready,
  output logic [WORDSIZE-1:0] dm_rdata,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WORDSIZE-1:0] mem_addr,
  output logic [WORDSIZE-1:0] mem_wdata,
  input  logic [WORDSIZE-1:0] mem_rdata,
  input  logic                mem_ack,
  output logic                err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_DM = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [TOSIZE-1:0]   cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [WORDSIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORDSIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic [INSTSIZE-1:0] if_data_q, if_data_d;
  logic [WORDSIZE-1:0] dm_rdata_q, dm_rdata_d;
  logic                err_q, err_d;
  logic                dm_pend, grant_dm;

`ifdef MEMARB_ROUNDROBIN_EN
  // ptr_q = 1 means data wins the next contended grant
  logic ptr_q, ptr_d;
`endif

  assign dm_pend = dm_read | dm_write;

`ifdef MEMARB_ROUNDROBIN_EN
  assign grant_dm = dm_pend & (~if_req | ptr_q);
`else
  // Data first: MEM holds the older instruction, so fetch-first could deadlock.
  assign grant_dm = dm_pend;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    if_data_d   = if_data_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
`ifdef MEMARB_ROUNDROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (if_req || dm_pend) begin
          mem_req_d = 1'b1;
          cnt_d     = '0;
`ifdef MEMARB_ROUNDROBIN_EN
          ptr_d     = ~grant_dm;
`endif
          if (grant_dm) begin
            state_d     = S_BUSY_DM;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            mem_we_d    = dm_write;
          end else begin
            state_d    = S_BUSY_IF;
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
          end
        end
      end
      S_BUSY_IF, S_BUSY_DM: begin
        if (mem_ack) begin
          if (state_q == S_BUSY_IF) begin
            if_data_d  = mem_rdata[INSTSIZE-1:0];
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) dm_rdata_d = mem_rdata;
            dm_ready_d = 1'b1;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_IDLE;
        end else if (cnt_q == TOSIZE'(TIMEOUT - 1)) begin
          // Abort without a ready pulse; the requester stays stalled and re-arbitrates.
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + TOSIZE'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
`ifdef MEMARB_ROUNDROBIN_EN
      ptr_q       <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      if_data_q   <= if_data_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
`ifdef MEMARB_ROUNDROBIN_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_data   = if_data_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign if_stall  = if_req & ~if_ready_q;
  assign dm_stall  = dm_pend & ~dm_ready_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one unified, single-ported memory between the IF-stage instruction fetch and the MEM-stage load/store.
- Sequences each access with a request/acknowledge handshake to the memory.
- Returns fetched instruction or loaded data to the requester.
- Drives per-requester stall signals to the hazard/pipeline control.
- Flags a sticky error if the memory fails to acknowledge within a bounded time.

Parameters:
- WORDSIZE, 64, width of addresses, write data and read data
- INSTSIZE, 32, width of returned instruction
- TIMEOUT, 15, max cycles in a busy state without mem_ack before abort; must be >= 1
- TOSIZE, 4, width of the timeout counter; must hold TIMEOUT

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  WORDSIZE  fetch address; stable while if_req
- if_ready  out  1  one-cycle pulse: fetch complete, if_data valid
- if_data  out  INSTSIZE  fetched instruction, mem_rdata[INSTSIZE-1:0]; holds until next fetch completes
- if_stall  out  1  if_req && !if_ready
- dm_read  in  1  load request; held until dm_ready
- dm_write  in  1  store request; held until dm_ready
- dm_addr  in  WORDSIZE  data address
- dm_wdata  in  WORDSIZE  store data
- dm_ready  out  1  one-cycle pulse: data access complete
- dm_rdata  out  WORDSIZE  load data; holds until next load completes
- dm_stall  out  1  (dm_read||dm_write) && !dm_ready
- mem_req  out  1  memory access in progress
- mem_we  out  1  1 = write
- mem_addr  out  WORDSIZE  latched address
- mem_wdata  out  WORDSIZE  latched write data
- mem_rdata  in  WORDSIZE  memory read data; valid with mem_ack
- mem_ack  in  1  memory completes the current access this cycle
- err  out  1  sticky timeout flag

Behaviour:
- Reset (async): state IDLE; mem_req, mem_we, if_ready, dm_ready, err = 0; mem_addr, mem_wdata, if_data, dm_rdata = 0; timeout counter = 0; priority pointer = data.
- States:
  - IDLE: no access outstanding.
  - BUSY_IF: fetch outstanding.
  - BUSY_DM: data access outstanding.
- IDLE, on a clock edge with a pending request:
  - Grant per the priority rule.
  - Latch addr/wdata/we into mem_* registers; set mem_req=1; counter=0.
  - Go to BUSY_IF or BUSY_DM.
- Default priority: data beats fetch. MEM holds an older instruction, and granting fetch first would deadlock the pipeline.
- dm_read and dm_write both high: treat as write; dm_rdata unchanged.
- In BUSY_x with mem_ack=1 at an edge:
  - Capture mem_rdata into if_data (BUSY_IF) or dm_rdata (BUSY_DM read).
  - Assert x_ready=1 for the next cycle only; mem_req=0; go to IDLE.
- In BUSY_x with mem_ack=0: counter += 1.
  - Counter reaching TIMEOUT: set err=1 (sticky until reset); mem_req=0; go to IDLE; no ready pulse.
  - The requester stays stalled and its request is re-arbitrated.
- Minimum latency: request sampled at edge N, mem_req high cycle N+1, ack in N+1, ready high cycle N+2.
- One access at a time; mem_addr, mem_we and mem_wdata stay stable throughout BUSY.
- The ready cycle is IDLE. A request still asserted at the end of the ready cycle is a new access and is granted at that edge.
- mem_ack while IDLE is ignored.
- Requests dropped mid-BUSY: the access still completes and the ready pulse is still emitted.
- Reset mid-access: the access is abandoned immediately, mem_req drops asynchronously, and no ready pulse is emitted.
- if_stall and dm_stall are combinational from inputs and the registered ready outputs.

Optional Feature:
- MEMARB_ROUNDROBIN_EN defined:
  - When both requesters are pending in IDLE, grant goes to the one not granted last. The pointer updates on every grant.
  - A single pending requester is always granted.
- Undefined: fixed priority, data beats fetch; the pointer register is absent.

Test Plan:
- Fetch only: if_req=1, if_addr=0x40; mem_ack=1 on the 3rd busy cycle with mem_rdata=0x8B020020 -> mem_req high 3 cycles with mem_addr=0x40, mem_we=0; if_ready pulses 1 cycle with if_data=0x8B020020; if_stall high until then.
- Simultaneous requests, macro off: if_req=1 and dm_read=1 with dm_addr=0x100 at the same edge, ack next cycle -> data granted first (mem_addr=0x100); fetch granted at the edge ending the dm_ready cycle.
- Simultaneous requests, macro on: three back-to-back contended rounds -> grants alternate data, fetch, data.
- Store: dm_write=1, dm_addr=0x18, dm_wdata=0xDEAD, ack after 1 cycle -> mem_we=1 and mem_wdata=0xDEAD during BUSY; dm_ready pulses; dm_rdata unchanged.
- Timeout: fetch with mem_ack held 0 -> after TIMEOUT=15 busy cycles mem_req drops and err=1 persists; no if_ready; re-grant occurs; a later ack completes normally with err still 1.
- Reset mid-access: assert rst during BUSY_DM -> mem_req, mem_we, dm_ready and err all 0 without waiting for a clock edge; state IDLE.
